// File: rtl/switch_debouncer.sv
// Slide-switch front end: synchronizes raw switch pins to clk, debounces each
// bit independently and emits one-cycle rise/fall pulses per accepted change.
module switch_debouncer #(
    parameter int unsigned WIDTH           = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] switches_raw,
    output logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);

    // A single-cycle debounce still needs one counter bit to hold the compare value.
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [WIDTH-1:0]           sync1_q;
    logic [WIDTH-1:0]           sync2_q;
    logic [WIDTH-1:0]           switches_q, switches_d;
    logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]           rise_q, rise_d;
    logic [WIDTH-1:0]           fall_q, fall_d;
    logic                       any_change_q, any_change_d;

    // Two-flop synchronizer; nothing may sit between the stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= switches_raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-bit debounce: count consecutive disagreeing cycles, accept on the last one.
    always_comb begin
        switches_d = switches_q;
        cnt_d      = cnt_q;
        rise_d     = '0;
        fall_d     = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync2_q[i] == switches_q[i]) begin
                // Any return to the stable level abandons the partial count.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                switches_d[i] = sync2_q[i];
                cnt_d[i]      = '0;
                rise_d[i]     = sync2_q[i];
                fall_d[i]     = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntOne;
            end
        end
    end

    // Summary pulse derived from next-state edges so it lines up with rise/fall.
    always_comb begin
        any_change_d = |(rise_d | fall_d);
    end

    // Debounce state and registered edge outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            switches_q   <= '0;
            cnt_q        <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            any_change_q <= 1'b0;
        end else begin
            switches_q   <= switches_d;
            cnt_q        <= cnt_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            any_change_q <= any_change_d;
        end
    end

    assign switches   = switches_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign any_change = any_change_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer (DEBOUNCE_CYCLES = 4): stimulus pushes the
// expected change events, a negedge monitor pops and checks them as they appear.
module tb_switch_debouncer;

    localparam int unsigned W = 10;
    localparam int unsigned N = 4;
    // Raw change driven before edge k shows up after edge k+N+1.
    localparam int unsigned LAT = N + 2;

    typedef struct {
        int unsigned  cyc;
        logic [W-1:0] sw;
        logic [W-1:0] r;
        logic [W-1:0] f;
    } event_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] switches_raw;
    logic [W-1:0] switches;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         any_change;

    int unsigned  cyc;
    int           n_checks;
    int           n_fail;
    event_t       exp_q[$];
    bit           done;

    switch_debouncer #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (N)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .switches_raw (switches_raw),
        .switches     (switches),
        .rise         (rise),
        .fall         (fall),
        .any_change   (any_change)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_event(input logic [W-1:0] sw, input logic [W-1:0] r,
                                input logic [W-1:0] f);
        event_t e;
        e.cyc = cyc + LAT;
        e.sw  = sw;
        e.r   = r;
        e.f   = f;
        exp_q.push_back(e);
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every negedge, consume an expected event when the DUT reports a change.
    initial begin
        event_t e;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (done) break;
            check("any_change_vs_edges", {31'd0, any_change}, {31'd0, |(rise | fall)});
            if (any_change === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event_rise", {22'd0, rise}, 32'd0);
                    check("unexpected_event_fall", {22'd0, fall}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_cycle", e.cyc <= cyc ? cyc - e.cyc : 32'hFFFF, 32'd0);
                    check("event_switches", {22'd0, switches}, {22'd0, e.sw});
                    check("event_rise", {22'd0, rise}, {22'd0, e.r});
                    check("event_fall", {22'd0, fall}, {22'd0, e.f});
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                e = exp_q.pop_front();
                check("event_missing_switches", {22'd0, switches}, {22'd0, e.sw});
                check("event_missing_any_change", {31'd0, any_change}, 32'd1);
            end
        end
    end

    // Stimulus: inputs change on negedges only.
    initial begin
        n_checks     = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        switches_raw = 10'h3FF;

        // Reset with all switches high at the pins.
        clocks(5);
        check("reset_switches", {22'd0, switches}, 32'd0);
        check("reset_rise", {22'd0, rise}, 32'd0);
        check("reset_fall", {22'd0, fall}, 32'd0);
        check("reset_any_change", {31'd0, any_change}, 32'd0);
        rst_n = 1'b1;
        expect_event(10'h3FF, 10'h3FF, 10'h000);
        clocks(LAT - 1);
        check("reset_release_not_early", {22'd0, switches}, 32'd0);
        clocks(6);

        // All back to zero.
        switches_raw = 10'h000;
        expect_event(10'h000, 10'h000, 10'h3FF);
        clocks(12);

        // Clean step on bit 0, up then down.
        switches_raw = 10'h001;
        expect_event(10'h001, 10'h001, 10'h000);
        clocks(12);
        switches_raw = 10'h000;
        expect_event(10'h000, 10'h000, 10'h001);
        clocks(12);

        // Bounce on bit 4: 2-cycle pulses never survive, final hold is accepted.
        switches_raw[4] = 1'b1;
        clocks(2);
        switches_raw[4] = 1'b0;
        clocks(2);
        switches_raw[4] = 1'b1;
        clocks(2);
        switches_raw[4] = 1'b0;
        clocks(2);
        check("bounce_no_change", {22'd0, switches}, 32'd0);
        switches_raw[4] = 1'b1;
        expect_event(10'h010, 10'h010, 10'h000);
        clocks(12);
        switches_raw[4] = 1'b0;
        expect_event(10'h000, 10'h000, 10'h010);
        clocks(12);

        // Glitch on bit 9 one cycle shorter than the debounce window.
        switches_raw[9] = 1'b1;
        clocks(3);
        switches_raw[9] = 1'b0;
        clocks(12);
        check("glitch_switches", {22'd0, switches}, 32'd0);

        // Simultaneous rise on four bits and fall on four others.
        switches_raw = 10'h00F;
        expect_event(10'h00F, 10'h00F, 10'h000);
        clocks(12);
        switches_raw = 10'h0F0;
        expect_event(10'h0F0, 10'h0F0, 10'h00F);
        clocks(12);

        // Reset mid-count on bit 2: partial count is discarded.
        switches_raw = 10'h0F4;
        clocks(3);
        rst_n = 1'b0;
        #1;
        check("async_reset_switches", {22'd0, switches}, 32'd0);
        check("async_reset_any_change", {31'd0, any_change}, 32'd0);
        clocks(1);
        rst_n = 1'b1;
        expect_event(10'h0F4, 10'h0F4, 10'h000);
        clocks(LAT - 1);
        check("midreset_not_early", {22'd0, switches}, 32'd0);
        clocks(8);

        check("all_events_seen", exp_q.size(), 32'd0);
        done = 1'b1;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
